// File: rtl/addr_decode_pipelined.sv
// Runtime-programmable address decoder: a rule table written through a config port,
// and a two-stage valid/ready pipeline (match, then priority resolve) that decodes one address per cycle.
module addr_decode_pipelined #(
  parameter int AddrWidth   = 32,
  parameter int NoIndices   = 4,
  parameter int NoRules     = 8,
  parameter bit Napot       = 1'b0,
  parameter int ErrCntWidth = 16,
  parameter int IdxWidth    = (NoIndices > 1) ? $clog2(NoIndices) : 1,
  parameter int RuleIdxW    = (NoRules > 1) ? $clog2(NoRules) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cfg_we_i,
  input  logic [RuleIdxW-1:0]    cfg_rule_i,
  input  logic                   cfg_en_i,
  input  logic [AddrWidth-1:0]   cfg_start_i,
  input  logic [AddrWidth-1:0]   cfg_end_i,
  input  logic [IdxWidth-1:0]    cfg_idx_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic                   en_default_idx_i,
  input  logic [IdxWidth-1:0]    default_idx_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [IdxWidth-1:0]    rsp_idx_o,
  output logic                   rsp_dec_valid_o,
  output logic                   rsp_dec_error_o,
  output logic                   rsp_multi_o,
  input  logic                   err_cnt_clr_i,
  output logic [ErrCntWidth-1:0] err_cnt_o
);

  // Rule table
  logic [NoRules-1:0]   rule_en;
  logic [AddrWidth-1:0] rule_start [NoRules];
  logic [AddrWidth-1:0] rule_end   [NoRules];
  logic [IdxWidth-1:0]  rule_idx   [NoRules];
  logic                 rule_wr_ok;

  assign rule_wr_ok = cfg_we_i && (int'(cfg_rule_i) < NoRules);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rule_en <= '0;
      for (int i = 0; i < NoRules; i++) begin
        rule_start[i] <= '0;
        rule_end[i]   <= '0;
        rule_idx[i]   <= '0;
      end
    end else if (rule_wr_ok) begin
      rule_en[cfg_rule_i]    <= cfg_en_i;
      rule_start[cfg_rule_i] <= cfg_start_i;
      rule_end[cfg_rule_i]   <= cfg_end_i;
      rule_idx[cfg_rule_i]   <= cfg_idx_i;
    end
  end

  // Match vector against the table as it stands before any same-edge write.
  logic [NoRules-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < NoRules; i++) begin
      if (Napot) begin
        match[i] = rule_en[i] &&
                   ((req_addr_i & ~rule_end[i]) == (rule_start[i] & ~rule_end[i]));
      end else begin
        match[i] = rule_en[i] && (rule_start[i] < rule_end[i]) &&
                   (req_addr_i >= rule_start[i]) && (req_addr_i < rule_end[i]);
      end
    end
  end

  // Handshake: a transfer happens on an edge where valid && ready. A stage may take new data
  // when it is empty or its content leaves on the same edge; ready never depends on the
  // incoming valid, and a held response keeps all rsp_* stable until rsp_ready_i.
  logic                s1_valid;
  logic [NoRules-1:0]  s1_match;
  logic                s1_en_default;
  logic [IdxWidth-1:0] s1_default_idx;
  logic                stage2_ready;

  assign stage2_ready = !rsp_valid_o || rsp_ready_i;
  assign req_ready_o  = !s1_valid || stage2_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid       <= 1'b0;
      s1_match       <= '0;
      s1_en_default  <= 1'b0;
      s1_default_idx <= '0;
    end else if (req_ready_o) begin
      s1_valid <= req_valid_i;
      if (req_valid_i) begin
        s1_match       <= match;
        s1_en_default  <= en_default_idx_i;
        s1_default_idx <= default_idx_i;
      end
    end
  end

  // Resolve: lowest-numbered matching rule wins.
  logic                win_found;
  logic [RuleIdxW-1:0] win_rule;
  logic [IdxWidth-1:0] res_idx;
  logic                res_dec_error;
  logic                res_multi;

  always_comb begin
    win_found = 1'b0;
    win_rule  = '0;
    for (int i = NoRules - 1; i >= 0; i--) begin
      if (s1_match[i]) begin
        win_found = 1'b1;
        win_rule  = RuleIdxW'(i);
      end
    end
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    res_multi = |(s1_match & (s1_match - NoRules'(1)));
    if (win_found) begin
      res_idx = rule_idx[win_rule];
    end else if (s1_en_default) begin
      res_idx = s1_default_idx;
    end else begin
      res_idx = '0;
    end
    res_dec_error = !win_found && !s1_en_default;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o     <= 1'b0;
      rsp_idx_o       <= '0;
      rsp_dec_valid_o <= 1'b0;
      rsp_dec_error_o <= 1'b0;
      rsp_multi_o     <= 1'b0;
    end else if (stage2_ready) begin
      rsp_valid_o <= s1_valid;
      if (s1_valid) begin
        rsp_idx_o       <= res_idx;
        rsp_dec_valid_o <= win_found;
        rsp_dec_error_o <= res_dec_error;
        rsp_multi_o     <= res_multi;
      end
    end
  end

  // Counts delivered error responses; clear dominates a coincident increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_o <= '0;
    end else if (err_cnt_clr_i) begin
      err_cnt_o <= '0;
    end else if (rsp_valid_o && rsp_ready_i && rsp_dec_error_o && !(&err_cnt_o)) begin
      err_cnt_o <= err_cnt_o + ErrCntWidth'(1);
    end
  end

endmodule

// File: tb/tb_addr_decode_pipelined.sv
// Bench for addr_decode_pipelined: a range-mode instance (2-bit error counter) and a NAPOT instance
// share one stimulus stream; each is scored against a rule-table reference model.
module tb_addr_decode_pipelined;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT inputs (driven only at negedge) ----------------
  logic        cfg_we = 1'b0, cfg_en = 1'b0;
  logic [2:0]  cfg_rule = '0;
  logic [31:0] cfg_start = '0, cfg_end = '0;
  logic [1:0]  cfg_idx = '0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        en_def = 1'b0;
  logic [1:0]  def_idx = '0;
  logic        rsp_ready = 1'b0;
  logic        err_clr = 1'b0;

  // next-cycle values set by the test sequence
  logic        nx_we = 1'b0, nx_en = 1'b0;
  logic [2:0]  nx_rule = '0;
  logic [31:0] nx_start = '0, nx_end = '0;
  logic [1:0]  nx_idx = '0;
  logic        nx_valid = 1'b0;
  logic [31:0] nx_addr = '0;
  logic        nx_en_def = 1'b0;
  logic [1:0]  nx_def_idx = '0;
  logic        nx_rsp_ready = 1'b1;
  logic        nx_clr = 1'b0;

  // ---------------- DUT outputs ----------------
  logic        req_ready_a, rsp_valid_a, rsp_dv_a, rsp_de_a, rsp_multi_a;
  logic [1:0]  rsp_idx_a, err_cnt_a;
  logic        req_ready_b, rsp_valid_b, rsp_dv_b, rsp_de_b, rsp_multi_b;
  logic [1:0]  rsp_idx_b;
  logic [15:0] err_cnt_b;

  addr_decode_pipelined #(.AddrWidth(32), .NoIndices(4), .NoRules(8), .Napot(1'b0), .ErrCntWidth(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_rule_i(cfg_rule), .cfg_en_i(cfg_en),
    .cfg_start_i(cfg_start), .cfg_end_i(cfg_end), .cfg_idx_i(cfg_idx),
    .req_valid_i(req_valid), .req_ready_o(req_ready_a), .req_addr_i(req_addr),
    .en_default_idx_i(en_def), .default_idx_i(def_idx),
    .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready), .rsp_idx_o(rsp_idx_a),
    .rsp_dec_valid_o(rsp_dv_a), .rsp_dec_error_o(rsp_de_a), .rsp_multi_o(rsp_multi_a),
    .err_cnt_clr_i(err_clr), .err_cnt_o(err_cnt_a));

  addr_decode_pipelined #(.AddrWidth(32), .NoIndices(4), .NoRules(8), .Napot(1'b1), .ErrCntWidth(16)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_rule_i(cfg_rule), .cfg_en_i(cfg_en),
    .cfg_start_i(cfg_start), .cfg_end_i(cfg_end), .cfg_idx_i(cfg_idx),
    .req_valid_i(req_valid), .req_ready_o(req_ready_b), .req_addr_i(req_addr),
    .en_default_idx_i(en_def), .default_idx_i(def_idx),
    .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready), .rsp_idx_o(rsp_idx_b),
    .rsp_dec_valid_o(rsp_dv_b), .rsp_dec_error_o(rsp_de_b), .rsp_multi_o(rsp_multi_b),
    .err_cnt_clr_i(err_clr), .err_cnt_o(err_cnt_b));

  // ---------------- reference model + scoreboard ----------------
  logic        m_en    [8];
  logic [31:0] m_start [8];
  logic [31:0] m_end   [8];
  logic [1:0]  m_idx   [8];
  int          m_err   [2];
  bit          hs_err  [2];

  // response word: {idx[1:0], dec_valid, dec_error, multi}
  logic [4:0] exp_q_a[$], exp_q_b[$], dir_q_a[$], dir_q_b[$];
  int         acc_q_a[$], acc_q_b[$];

  int passed = 0, total = 0, fails = 0;
  int cur_step = 0;
  bit last_acc;

  function automatic logic [4:0] model(input logic [31:0] a, input bit napot,
                                       input logic ed, input logic [1:0] di);
    int first = -1;
    int hits = 0;
    for (int r = 0; r < 8; r++) begin
      bit hit;
      if (napot) hit = m_en[r] && ((a & ~m_end[r]) == (m_start[r] & ~m_end[r]));
      else       hit = m_en[r] && (a >= m_start[r]) && (a < m_end[r]);
      if (hit) begin
        hits++;
        if (first < 0) first = r;
      end
    end
    if (first >= 0) return {m_idx[first], 1'b1, 1'b0, hits > 1};
    return {(ed ? di : 2'd0), 1'b0, !ed, hits > 1};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at step %0d", tag, obs, exp, cur_step);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) begin
      m_en[r] = 1'b0; m_start[r] = '0; m_end[r] = '0; m_idx[r] = '0;
    end
    m_err[0] = 0; m_err[1] = 0;
    exp_q_a.delete(); exp_q_b.delete(); dir_q_a.delete(); dir_q_b.delete();
    acc_q_a.delete(); acc_q_b.delete();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_rsp_a"}, {rsp_valid_a, rsp_idx_a, rsp_dv_a, rsp_de_a, rsp_multi_a}, 0);
    check({tag, "_rsp_b"}, {rsp_valid_b, rsp_idx_b, rsp_dv_b, rsp_de_b, rsp_multi_b}, 0);
    check({tag, "_err_a"}, err_cnt_a, 0);
    check({tag, "_err_b"}, err_cnt_b, 0);
    check({tag, "_ready"}, {req_ready_a, req_ready_b}, 2'b11);
  endtask

  task automatic check_side(input bit s);
    logic       rv, rr;
    logic [4:0] rsp, exp0;
    int         ec, sz, acc0;
    string      n;
    n = s ? "b" : "a";
    exp0 = '0; acc0 = 0;
    if (s) begin
      rv = rsp_valid_b; rr = req_ready_b; ec = int'(err_cnt_b);
      rsp = {rsp_idx_b, rsp_dv_b, rsp_de_b, rsp_multi_b};
      sz = exp_q_b.size();
      if (sz > 0) begin exp0 = exp_q_b[0]; acc0 = acc_q_b[0]; end
    end else begin
      rv = rsp_valid_a; rr = req_ready_a; ec = int'(err_cnt_a);
      rsp = {rsp_idx_a, rsp_dv_a, rsp_de_a, rsp_multi_a};
      sz = exp_q_a.size();
      if (sz > 0) begin exp0 = exp_q_a[0]; acc0 = acc_q_a[0]; end
    end
    // oldest undelivered item is at the output once two edges have passed since its accept
    check({n, "_rsp_valid"}, rv, (sz > 0) && (cur_step >= acc0 + 2));
    check({n, "_req_ready"}, rr, (sz < 2) || rsp_ready);
    check({n, "_err_cnt"}, 64'(ec), 64'(m_err[s]));
    hs_err[s] = 1'b0;
    if (rv && sz > 0) begin
      check({n, "_rsp"}, rsp, exp0);
      if (rsp_ready) begin
        hs_err[s] = exp0[1];
        if (s) begin
          void'(exp_q_b.pop_front()); void'(acc_q_b.pop_front());
          if (dir_q_b.size() > 0) check("b_directed", rsp, dir_q_b.pop_front());
        end else begin
          void'(exp_q_a.pop_front()); void'(acc_q_a.pop_front());
          if (dir_q_a.size() > 0) check("a_directed", rsp, dir_q_a.pop_front());
        end
      end
    end
    if (req_valid && rr) begin
      if (s) begin exp_q_b.push_back(model(req_addr, 1'b1, en_def, def_idx)); acc_q_b.push_back(cur_step); end
      else   begin exp_q_a.push_back(model(req_addr, 1'b0, en_def, def_idx)); acc_q_a.push_back(cur_step); end
    end
    if (!s) last_acc = req_valid && rr;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    cfg_we = nx_we; cfg_rule = nx_rule; cfg_en = nx_en; cfg_start = nx_start;
    cfg_end = nx_end; cfg_idx = nx_idx; req_valid = nx_valid; req_addr = nx_addr;
    en_def = nx_en_def; def_idx = nx_def_idx; rsp_ready = nx_rsp_ready; err_clr = nx_clr;
    cur_step++;
    #1;
    check_side(1'b0);
    check_side(1'b1);
    @(posedge clk);
    for (int s = 0; s < 2; s++) begin
      if (err_clr) m_err[s] = 0;
      else if (hs_err[s] && m_err[s] < (s ? 65535 : 3)) m_err[s]++;
    end
    if (cfg_we) begin
      m_en[cfg_rule] = cfg_en; m_start[cfg_rule] = cfg_start;
      m_end[cfg_rule] = cfg_end; m_idx[cfg_rule] = cfg_idx;
    end
    nx_we = 1'b0;
    nx_clr = 1'b0;
  endtask

  task automatic set_rule(input logic [2:0] r, input logic en, input logic [31:0] st,
                          input logic [31:0] en_addr, input logic [1:0] idx);
    nx_we = 1'b1; nx_rule = r; nx_en = en; nx_start = st; nx_end = en_addr; nx_idx = idx;
  endtask

  task automatic send(input logic [31:0] a);
    nx_valid = 1'b1; nx_addr = a;
    step();
    nx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    nx_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic drain(input string tag);
    int k = 0;
    nx_valid = 1'b0; nx_rsp_ready = 1'b1;
    while ((exp_q_a.size() > 0 || exp_q_b.size() > 0) && k < 20) begin
      step();
      k++;
    end
    check({tag, "_drained"}, {exp_q_a.size() == 0, exp_q_b.size() == 0}, 2'b11);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0; req_valid = 1'b0; cfg_we = 1'b0; err_clr = 1'b0;
    nx_valid = 1'b0; nx_we = 1'b0; nx_clr = 1'b0;
    #1;
    reset_checks("midrst");
    model_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] bp_addr [6];
  logic [4:0]  bp_exp  [6];
  bit          bp_pat  [4];

  initial begin
    int i, k, stalls;
    model_reset();
    bp_addr = '{32'h1000, 32'h2800, 32'h3000, 32'h0010, 32'h4000, 32'h2FFF};
    bp_exp  = '{5'b01101, 5'b10101, 5'b11100, 5'b11100, 5'b00010, 5'b10101};
    bp_pat  = '{1'b1, 1'b0, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    #1;
    reset_checks("reset");
    #1;
    rst_n = 1'b1;

    // basic range decode, default off
    set_rule(3'd0, 1'b1, 32'h1000, 32'h2000, 2'd1); step();
    set_rule(3'd1, 1'b1, 32'h2000, 32'h3000, 2'd2); step();
    dir_q_a.push_back(5'b01100); send(32'h1FFF);
    dir_q_a.push_back(5'b10100); send(32'h2000);
    dir_q_a.push_back(5'b00010); send(32'h3000);
    idle(3);

    // overlapping rule
    set_rule(3'd3, 1'b1, 32'h0000, 32'h4000, 2'd3); step();
    dir_q_a.push_back(5'b10101); send(32'h2800);
    idle(3);

    // backpressure with ready pattern 1,0,0,1
    for (int j = 0; j < 6; j++) dir_q_a.push_back(bp_exp[j]);
    i = 0; k = 0; stalls = 0;
    while ((i < 6 || exp_q_a.size() > 0) && k < 60) begin
      nx_valid = (i < 6);
      nx_addr = bp_addr[(i < 6) ? i : 0];
      nx_rsp_ready = bp_pat[k % 4];
      step();
      if (!req_ready_a) stalls++;
      if (last_acc) i++;
      k++;
    end
    check("bp_all_accepted", 64'(i), 64'd6);
    check("bp_stall_seen", 64'(stalls > 0), 64'd1);
    check("bp_dir_empty", 64'(dir_q_a.size()), 64'd0);
    drain("bp");

    // same-edge write: the accepted request sees the old table
    set_rule(3'd4, 1'b1, 32'h5000, 32'h6000, 2'd0);
    dir_q_a.push_back(5'b00010); send(32'h5000);
    dir_q_a.push_back(5'b00100); send(32'h5000);
    idle(3);

    // reset with both stages full
    nx_rsp_ready = 1'b0;
    nx_valid = 1'b1; nx_addr = 32'h1000;
    repeat (3) step();
    check("full_ready_low", req_ready_a, 1'b0);
    mid_reset();
    nx_rsp_ready = 1'b1;
    idle(3);
    dir_q_a.push_back(5'b00010); dir_q_b.push_back(5'b00010); send(32'h1000);
    idle(3);

    // NAPOT rule; range instance treats it as start >= end
    set_rule(3'd0, 1'b1, 32'h8000, 32'h0FFF, 2'd2); step();
    dir_q_a.push_back(5'b00010); dir_q_b.push_back(5'b10100); send(32'h8ABC);
    nx_en_def = 1'b1; nx_def_idx = 2'd3;
    dir_q_a.push_back(5'b11000); dir_q_b.push_back(5'b11000); send(32'h9000);
    dir_q_a.push_back(5'b11000); dir_q_b.push_back(5'b10100); send(32'h8FFF);
    idle(3);
    check("napot_dir_empty", {dir_q_a.size() == 0, dir_q_b.size() == 0}, 2'b11);
    nx_en_def = 1'b0;

    // error counter saturation and clear-wins
    nx_clr = 1'b1; step();
    for (int e = 1; e <= 5; e++) begin
      send(32'hF000);
      idle(2);
      #1;
      check("errcnt_sat", err_cnt_a, (e < 3) ? e : 3);
    end
    nx_rsp_ready = 1'b0;
    send(32'hF000);
    idle(2);
    nx_rsp_ready = 1'b1; nx_clr = 1'b1;
    step();
    #1;
    check("errcnt_clr_wins_a", err_cnt_a, 0);
    check("errcnt_clr_wins_b", err_cnt_b, 0);

    // randomized rounds
    for (int round = 0; round < 4; round++) begin
      drain("rnd_pre");
      for (int r = 0; r < 8; r++) begin
        logic [31:0] base, len, e_val;
        base = 32'($urandom_range(0, 15)) << 12;
        len  = ($urandom_range(0, 3) == 0) ? 32'd0 : (32'($urandom_range(1, 8)) << 10);
        case ($urandom_range(0, 3))
          0:       e_val = base - len;
          1:       e_val = (32'd1 << $urandom_range(8, 14)) - 32'd1;
          default: e_val = base + len;
        endcase
        set_rule(3'(r), ($urandom_range(0, 4) != 0), base, e_val, 2'($urandom_range(0, 3)));
        step();
      end
      for (int t = 0; t < 80; t++) begin
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 7);
        case ($urandom_range(0, 4))
          0:       a = m_start[r];
          1:       a = m_start[r] - 32'd1;
          2:       a = m_end[r];
          3:       a = m_end[r] - 32'd1;
          default: a = 32'($urandom_range(0, 32'hFFFF));
        endcase
        nx_valid = ($urandom_range(0, 3) != 0);
        nx_addr = a;
        nx_en_def = 1'($urandom_range(0, 1));
        nx_def_idx = 2'($urandom_range(0, 3));
        nx_rsp_ready = ($urandom_range(0, 9) < 7);
        nx_clr = ($urandom_range(0, 24) == 0);
        step();
      end
    end

    drain("final");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
